// File: rtl/countdown_ctrl.sv
// Run/pause/done/clear sequencer for the MM:SS countdown chain.
// Emits one units-seconds decrease strobe per second and a blinking alarm at zero.
module countdown_ctrl #(
    parameter int unsigned TICK_DIV    = 100,
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic       clk_out,
    input  logic       reset_n,
    input  logic       start_pause,
    input  logic       clear,
    input  logic       all_zero,
    output logic       decrease,
    output logic [2:0] state,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StPause = 3'd2,
        StDone  = 3'd3,
        StClear = 3'd4
    } state_e;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

    state_e        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          decrease_d, alarm_d, tick;

    always_comb begin
        tick       = ((state_q == StRun) || (state_q == StDone)) && (p_q == PW'(TICK_DIV - 1));
        state_d    = state_q;
        p_d        = '0;
        cnt_d      = cnt_q;
        decrease_d = 1'b0;
        alarm_d    = 1'b0;

        if (clear) begin
            state_d = StClear;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_pause && !all_zero) state_d = StRun;
                end
                StRun: begin
                    // Pausing freezes the prescaler so resume keeps the phase.
                    if (start_pause) begin
                        state_d = StPause;
                        p_d     = p_q;
                    end else if (tick) begin
                        if (all_zero) begin
                            state_d = StDone;
                            cnt_d   = '0;
                            alarm_d = 1'b1;
                        end else begin
                            decrease_d = 1'b1;
                        end
                    end else begin
                        p_d = p_q + PW'(1);
                    end
                end
                StPause: begin
                    p_d = p_q;
                    if (start_pause) state_d = StRun;
                end
                StDone: begin
                    alarm_d = alarm;
                    if (start_pause) begin
                        state_d = StIdle;
                        alarm_d = 1'b0;
                    end else if (tick) begin
                        if (cnt_q == AW'(ALARM_TICKS - 1)) begin
                            state_d = StIdle;
                            alarm_d = 1'b0;
                        end else begin
                            cnt_d   = cnt_q + AW'(1);
                            alarm_d = ~alarm;
                        end
                    end else begin
                        p_d = p_q + PW'(1);
                    end
                end
                StClear: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_out or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            p_q      <= '0;
            cnt_q    <= '0;
            decrease <= 1'b0;
            running  <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            decrease <= decrease_d;
            running  <= (state_d == StRun);
            alarm    <= alarm_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl: stimulus queues expected output events,
// a negedge monitor pops one per observed output change and compares time and value.
module tb_countdown_ctrl;

    logic       clk_out = 1'b0;
    logic       reset_n;
    logic       start_pause;
    logic       clear;
    logic       all_zero;
    logic       decrease;
    logic [2:0] state;
    logic       running;
    logic       alarm;

    countdown_ctrl #(
        .TICK_DIV    (4),
        .ALARM_TICKS (4)
    ) dut (
        .clk_out     (clk_out),
        .reset_n     (reset_n),
        .start_pause (start_pause),
        .clear       (clear),
        .all_zero    (all_zero),
        .decrease    (decrease),
        .state       (state),
        .running     (running),
        .alarm       (alarm)
    );

    always #5 clk_out = ~clk_out;

    typedef struct packed {
        int unsigned at;
        logic [5:0]  o;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int          secs = 0;
    int          load_val = 0;
    logic        load = 1'b0;
    logic        mon_en = 1'b0;
    logic [5:0]  obs;

    assign obs      = {state, running, alarm, decrease};
    assign all_zero = (secs == 0);

    always @(posedge clk_out) cyc <= cyc + 1;

    // Digit chain model: counts down on decrease, zeroes while in CLEAR.
    always @(posedge clk_out) begin
        if (load) secs <= load_val;
        else if (state == 3'd4) secs <= 0;
        else if (decrease && secs > 0) secs <= secs - 1;
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_ev(input int unsigned at, input logic [2:0] st, input logic run,
                             input logic alm, input logic dec);
        ev_t e;
        e.at = at;
        e.o  = {st, run, alm, dec};
        exp_q.push_back(e);
    endtask

    task automatic step_to(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk_out);
            #1;
        end
    endtask

    task automatic load_time(input int v);
        @(posedge clk_out);
        #1;
        load_val = v;
        load     = 1'b1;
        @(posedge clk_out);
        #1;
        load = 1'b0;
    endtask

    task automatic pulse_sp();
        start_pause = 1'b1;
        @(posedge clk_out);
        #1;
        start_pause = 1'b0;
    endtask

    // Monitor: every change of the output vector is one DUT event.
    initial begin
        logic [5:0] last;
        ev_t        e;
        wait (mon_en);
        last = obs;
        forever begin
            @(negedge clk_out);
            if (obs !== last) begin
                last = obs;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {26'd0, obs}, {26'd0, 6'h3f});
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.at);
                    check("event_outputs", {26'd0, obs}, {26'd0, e.o});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s;
        reset_n     = 1'b1;
        start_pause = 1'b0;
        clear       = 1'b0;
        #2 reset_n  = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_running", running, 0);
        check("rst_alarm", alarm, 0);
        check("rst_decrease", decrease, 0);
        @(posedge clk_out);
        @(posedge clk_out);
        #3 reset_n = 1'b1;
        mon_en     = 1'b1;

        // 00:03 run to zero, then full alarm sequence back to IDLE.
        load_time(3);
        s = cyc + 1;
        expect_ev(s,      3'd1, 1, 0, 0);
        expect_ev(s + 4,  3'd1, 1, 0, 1);
        expect_ev(s + 5,  3'd1, 1, 0, 0);
        expect_ev(s + 8,  3'd1, 1, 0, 1);
        expect_ev(s + 9,  3'd1, 1, 0, 0);
        expect_ev(s + 12, 3'd1, 1, 0, 1);
        expect_ev(s + 13, 3'd1, 1, 0, 0);
        expect_ev(s + 16, 3'd3, 0, 1, 0);
        expect_ev(s + 20, 3'd3, 0, 0, 0);
        expect_ev(s + 24, 3'd3, 0, 1, 0);
        expect_ev(s + 28, 3'd3, 0, 0, 0);
        expect_ev(s + 32, 3'd0, 0, 0, 0);
        pulse_sp();
        step_to(s + 36);

        // Pause at p=2, hold 20 cycles, resume, then clear+start_pause on a tick.
        load_time(5);
        s = cyc + 1;
        expect_ev(s,      3'd1, 1, 0, 0);
        expect_ev(s + 3,  3'd2, 0, 0, 0);
        expect_ev(s + 23, 3'd1, 1, 0, 0);
        expect_ev(s + 25, 3'd1, 1, 0, 1);
        expect_ev(s + 26, 3'd1, 1, 0, 0);
        expect_ev(s + 29, 3'd4, 0, 0, 0);
        expect_ev(s + 30, 3'd0, 0, 0, 0);
        pulse_sp();
        step_to(s + 2);
        pulse_sp();
        step_to(s + 22);
        pulse_sp();
        step_to(s + 28);
        clear       = 1'b1;
        start_pause = 1'b1;
        @(posedge clk_out);
        #1;
        clear       = 1'b0;
        start_pause = 1'b0;
        step_to(s + 34);

        // start_pause with all digits zero: nothing happens.
        s = cyc + 1;
        pulse_sp();
        step_to(s + 8);
        check("idle_zero_state", state, 0);
        check("idle_zero_running", running, 0);

        // Alarm acknowledged by start_pause on the second DONE tick.
        load_time(1);
        s = cyc + 1;
        expect_ev(s,      3'd1, 1, 0, 0);
        expect_ev(s + 4,  3'd1, 1, 0, 1);
        expect_ev(s + 5,  3'd1, 1, 0, 0);
        expect_ev(s + 8,  3'd3, 0, 1, 0);
        expect_ev(s + 12, 3'd3, 0, 0, 0);
        expect_ev(s + 16, 3'd0, 0, 0, 0);
        pulse_sp();
        step_to(s + 15);
        pulse_sp();
        step_to(s + 20);

        // Asynchronous reset while the decrease strobe is high.
        load_time(5);
        s = cyc + 1;
        expect_ev(s,     3'd1, 1, 0, 0);
        expect_ev(s + 4, 3'd1, 1, 0, 1);
        expect_ev(s + 5, 3'd0, 0, 0, 0);
        pulse_sp();
        step_to(s + 4);
        #6 reset_n = 1'b0;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_decrease", decrease, 0);
        check("async_rst_running", running, 0);
        check("async_rst_alarm", alarm, 0);
        @(posedge clk_out);
        #3 reset_n = 1'b1;
        repeat (10) @(posedge clk_out);
        #1;
        check("post_rst_state", state, 0);
        check("post_rst_running", running, 0);
        repeat (2) @(posedge clk_out);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
